// File: rtl/decoder3_8_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder3_8_stream_if
// Purpose  : Stream bundle for the registered 3-to-8 decoder. It carries the
//            input code stream (En/Din with valid/ready) and the decoded
//            one-hot output stream (Do with valid/ready).
// Modports : master - drives codes in and consumes decoded words (producer/sink)
//            slave  - the decoder side
// Signals  : En, Din[2:0], Din_valid -> ; Din_ready <-
//            Do[7:0], Do_valid <- ; Do_ready ->   (arrows seen from master)
// Revision : 1.0 initial release
// ============================================================================
interface decoder3_8_stream_if;
  logic       En;
  logic [2:0] Din;
  logic       Din_valid;
  logic       Din_ready;
  logic [7:0] Do;
  logic       Do_valid;
  logic       Do_ready;

  modport master (
    output En, Din, Din_valid, Do_ready,
    input  Din_ready, Do, Do_valid
  );

  modport slave (
    input  En, Din, Din_valid, Do_ready,
    output Din_ready, Do, Do_valid
  );
endinterface
`default_nettype wire

// File: rtl/decoder3_8_stream.sv
`default_nettype none
// ============================================================================
// Module   : decoder3_8_stream
// Purpose  : Registered 3-to-8 one-hot decoder with valid/ready flow control.
//            A main output register plus one skid register give full
//            throughput while Din_ready comes straight from a flop.
// Ports    : clk    - rising-edge clock
//            rst    - asynchronous active-high reset
//            bus    - decoder3_8_stream_if.slave (En/Din/Din_valid/Din_ready,
//                     Do/Do_valid/Do_ready)
//            Dcount - 16-bit output-transfer counter (only when
//                     DECODER3_8_STATS_EN is defined)
// Options  : DECODER3_8_STATS_EN - adds the Dcount statistics port
// Revision : 1.0 initial release
// ============================================================================
module decoder3_8_stream (
  input  wire                        clk,
  input  wire                        rst,
  decoder3_8_stream_if.slave         bus
`ifdef DECODER3_8_STATS_EN
  ,
  output logic [15:0]                Dcount
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // main invalid, skid invalid
    ST_FULL  = 2'd1,   // main valid,   skid invalid
    ST_SKID  = 2'd2    // main valid,   skid valid
  } state_t;

  state_t     r_state;
  logic [7:0] r_do;
  logic       r_do_valid;
  logic [7:0] r_skid;
  logic       r_din_ready;   // registered copy of "skid not valid"

  logic       w_accept;
  logic       w_out_xfer;
  logic [7:0] w_word;

  assign w_accept   = bus.Din_valid & r_din_ready;
  assign w_out_xfer = r_do_valid & bus.Do_ready;
  // Decode at accept time so a later En change cannot touch a stored word.
  assign w_word     = bus.En ? (8'b1 << bus.Din) : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_do        <= 8'h00;
      r_do_valid  <= 1'b0;
      r_skid      <= 8'h00;
      r_din_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_do       <= w_word;
            r_do_valid <= 1'b1;
            r_state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_out_xfer) begin
            // Main drains and refills on the same edge.
            r_do <= w_word;
          end else if (w_accept) begin
            r_skid      <= w_word;
            r_din_ready <= 1'b0;
            r_state     <= ST_SKID;
          end else if (w_out_xfer) begin
            r_do_valid <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          // Din_ready is low here, so only the output side can move.
          if (w_out_xfer) begin
            r_do        <= r_skid;
            r_din_ready <= 1'b1;
            r_state     <= ST_FULL;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_do_valid  <= 1'b0;
          r_din_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Do        = r_do;
  assign bus.Do_valid  = r_do_valid;
  assign bus.Din_ready = r_din_ready;

`ifdef DECODER3_8_STATS_EN
  logic [15:0] r_dcount;

  // Free-running 16-bit count of output transfers; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcount <= 16'h0000;
    end else if (w_out_xfer) begin
      r_dcount <= r_dcount + 16'd1;
    end
  end

  assign Dcount = r_dcount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder3_8_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder3_8_stream
// Purpose  : Directed self-checking bench for decoder3_8_stream.
// Revision : 1.0 initial release
// ============================================================================
module tb_decoder3_8_stream;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decoder3_8_stream_if bus ();

`ifdef DECODER3_8_STATS_EN
  logic [15:0] Dcount;
`endif

  decoder3_8_stream dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave)
`ifdef DECODER3_8_STATS_EN
    ,
    .Dcount (Dcount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sweep [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sweep[0] = 8'h01; exp_sweep[1] = 8'h02; exp_sweep[2] = 8'h04; exp_sweep[3] = 8'h08;
    exp_sweep[4] = 8'h10; exp_sweep[5] = 8'h20; exp_sweep[6] = 8'h40; exp_sweep[7] = 8'h80;

    rst           = 1'b1;
    bus.En        = 1'b1;
    bus.Din       = 3'd0;
    bus.Din_valid = 1'b1;   // ignored during reset
    bus.Do_ready  = 1'b0;
    step();
    step();
    check("rst_do",       {24'h0, bus.Do}, 32'h00);
    check("rst_do_valid", {31'h0, bus.Do_valid}, 32'h0);
    check("rst_din_ready",{31'h0, bus.Din_ready}, 32'h1);
`ifdef DECODER3_8_STATS_EN
    check("rst_dcount",   {16'h0, Dcount}, 32'h0);
`endif
    rst           = 1'b0;
    bus.Din_valid = 1'b0;

    // ---- Sweep 0..7 with full throughput ----
    bus.Do_ready  = 1'b1;
    bus.En        = 1'b1;
    bus.Din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.Din = 3'(i);
      step();
      check($sformatf("sweep_do_%0d", i), {24'h0, bus.Do}, {24'h0, exp_sweep[i]});
      check($sformatf("sweep_v_%0d", i),  {31'h0, bus.Do_valid}, 32'h1);
      check($sformatf("sweep_r_%0d", i),  {31'h0, bus.Din_ready}, 32'h1);
    end

    // ---- Enable low ----
    bus.En  = 1'b0;
    bus.Din = 3'd5;
    step();
    check("en0_do",    {24'h0, bus.Do}, 32'h00);
    check("en0_valid", {31'h0, bus.Do_valid}, 32'h1);
    bus.Din_valid = 1'b0;
    bus.En        = 1'b1;
    step();
    check("en0_drain", {31'h0, bus.Do_valid}, 32'h0);

    // ---- Backpressure ----
    bus.Do_ready  = 1'b0;
    bus.Din_valid = 1'b1;
    bus.Din       = 3'd3;
    step();
    check("bp_do_a",  {24'h0, bus.Do}, 32'h08);
    check("bp_rdy_a", {31'h0, bus.Din_ready}, 32'h1);
    bus.Din = 3'd6;
    step();
    check("bp_do_b",  {24'h0, bus.Do}, 32'h08);
    check("bp_rdy_b", {31'h0, bus.Din_ready}, 32'h0);
    bus.Din = 3'd1;         // presented while skid full: must not be taken
    step();
    check("bp_do_c",  {24'h0, bus.Do}, 32'h08);
    check("bp_rdy_c", {31'h0, bus.Din_ready}, 32'h0);
    bus.Do_ready = 1'b1;    // 08 leaves at the next edge
    step();
    check("bp_do_d",  {24'h0, bus.Do}, 32'h40);
    check("bp_rdy_d", {31'h0, bus.Din_ready}, 32'h1);
    step();                 // 40 leaves, Din=1 accepted
    check("bp_do_e",  {24'h0, bus.Do}, 32'h02);
    check("bp_v_e",   {31'h0, bus.Do_valid}, 32'h1);
    bus.Din_valid = 1'b0;
    step();                 // 02 leaves
    check("bp_drain", {31'h0, bus.Do_valid}, 32'h0);

    // ---- Simultaneous accept and transfer in FULL ----
    bus.Din_valid = 1'b1;
    bus.Din       = 3'd4;
    step();
    check("sim_do_a", {24'h0, bus.Do}, 32'h10);
    bus.Din = 3'd7;
    step();
    check("sim_do_b", {24'h0, bus.Do}, 32'h80);
    check("sim_rdy",  {31'h0, bus.Din_ready}, 32'h1);
    bus.Din_valid = 1'b0;
    step();
    check("sim_drain", {31'h0, bus.Do_valid}, 32'h0);

    // ---- Mid-operation asynchronous reset in SKID ----
    bus.Do_ready  = 1'b0;
    bus.Din_valid = 1'b1;
    bus.Din       = 3'd2;
    step();
    bus.Din = 3'd5;
    step();
    check("mr_do_pre",  {24'h0, bus.Do}, 32'h04);
    check("mr_rdy_pre", {31'h0, bus.Din_ready}, 32'h0);
    bus.Din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mr_do",    {24'h0, bus.Do}, 32'h00);
    check("mr_valid", {31'h0, bus.Do_valid}, 32'h0);
    check("mr_rdy",   {31'h0, bus.Din_ready}, 32'h1);
    bus.Do_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("mr_after", {31'h0, bus.Do_valid}, 32'h0);

`ifdef DECODER3_8_STATS_EN
    // ---- Statistics counter ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("st_zero", {16'h0, Dcount}, 32'h0);
    bus.Do_ready  = 1'b1;
    bus.Din_valid = 1'b1;
    bus.Din       = 3'd0;
    step();                 // first accept, nothing yet to transfer
    check("st_first", {16'h0, Dcount}, 32'h0);
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 65535) check("st_ffff", {16'h0, Dcount}, 32'hFFFF);
      if (i == 65536) check("st_wrap", {16'h0, Dcount}, 32'h0);
    end
    check("st_70000", {16'h0, Dcount}, 32'd4464);
    bus.Do_ready = 1'b0;
    step();
    step();
    step();
    check("st_hold", {16'h0, Dcount}, 32'd4464);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
